instr_fetch_stage: RTL
======================

// Module: instr_fetch_stage
// PURPOSE
//  Fetch stage plus IF/ID pipeline register.
//  - Owns the PC and drives a single-outstanding request/response interface to instruction memory.
//  - Presents the fetched word to decode; the decode controller takes OpCode=IfIdInstr[31:26],
//    Rt=IfIdInstr[20:16] and Funct=IfIdInstr[5:0].
//  - Honours stalls from the hazard unit and PC redirects from branch/jump/jr resolution.
// PARAMETERS
//  RESET_PC  32'h0000_0000  PC loaded on reset
//  CNT_W     32             width of the delivered-instruction counter
// PORTS
//  Clk          in   1      clock, rising edge
//  Reset        in   1      asynchronous, active-high reset
//  Stall        in   1      hold the IF/ID register and PC (hazard unit)
//  Redirect     in   1      load RedirectPC; squash IF/ID and any in-flight fetch
//  RedirectPC   in   32     target for branch/j/jal/jr
//  ImemReq      out  1      one-cycle request pulse
//  ImemAddr     out  32     word-aligned fetch address, valid while ImemReq=1
//  ImemRData    in   32     instruction word, valid with ImemValid
//  ImemValid    in   1      response strobe; earliest 1 cycle after ImemReq
//  IfIdInstr    out  32     instruction to decode (0 = nop when invalid)
//  IfIdPCPlus4  out  32     fetch address + 4 of IfIdInstr (jal link, branch base)
//  IfIdValid    out  1      IfIdInstr holds a real instruction
//  InstrCount   out  CNT_W  number of instructions delivered to IF/ID
// BEHAVIOUR
//  Reset values (asynchronous):
//  - PC=RESET_PC, state=IDLE, Kill=0, ImemReq=0, ImemAddr=0.
//  - IfIdInstr=0, IfIdPCPlus4=0, IfIdValid=0, InstrCount=0, hold buffer=0.
//  States: IDLE, WAIT (request outstanding), HOLD (response buffered while stalled).
//  IDLE:
//  - Lasts exactly one cycle after Reset deasserts, then goes to WAIT.
//  - If Redirect is asserted in this cycle, PC loads RedirectPC first.
//  Request issue:
//  - On each entry to WAIT, ImemReq=1 for exactly one cycle with ImemAddr=PC.
//  - At most one request is outstanding at any time.
//  WAIT, ImemValid=1, Kill=0, Stall=0:
//  - IfIdInstr<=ImemRData, IfIdPCPlus4<=PC+4, IfIdValid<=1, InstrCount++.
//  - PC<=PC+4; re-enter WAIT, so the next ImemReq follows the next cycle.
//  - Sustained throughput with 1-cycle memory is one instruction per 2 cycles.
//  WAIT, ImemValid=1, Kill=0, Stall=1:
//  - Buffer ImemRData; go to HOLD. IF/ID is unchanged.
//  HOLD, Stall=0:
//  - Move the buffer into IF/ID (same updates as above); PC<=PC+4; go to WAIT.
//  Stall=1 in any state: IF/ID, PC and InstrCount hold; no new request is issued.
//  Redirect (priority over Stall and over ImemValid):
//  - Actions: PC<={RedirectPC[31:2],2'b00}; IfIdValid<=0; IfIdInstr<=0; hold buffer discarded.
//  - Redirect in WAIT with no response this cycle: Kill<=1, stay in WAIT.
//  - Redirect in WAIT coinciding with ImemValid: the response is dropped; re-enter WAIT and
//    request RedirectPC next cycle.
//  - Redirect in HOLD: go to WAIT and request the new PC next cycle.
//  WAIT, ImemValid=1, Kill=1:
//  - Drop the data; Kill<=0; re-enter WAIT and request PC (the redirected target).
//  Stray traffic: ImemValid outside WAIT is ignored.
//  Arithmetic:
//  - PC+4 and InstrCount wrap modulo 2^32 and 2^CNT_W respectively, with no flag.
//  Reset mid-operation: all state returns to reset values immediately; an outstanding
//  response arriving after Reset deasserts is ignored, since the block is in IDLE.
// TESTING
//  1. Release Reset, memory latency 1 -> ImemReq at cycle 2 with addr 0x0; IfIdValid=1 at cycle 4
//     with IfIdPCPlus4=0x4; next request at addr 0x4.
//  2. Run 8 fetches back-to-back, memory returns addr as data -> IfIdInstr sequence 0x0,0x4,...,0x1C;
//     InstrCount=8.
//  3. Stall=1 for 5 cycles while a response arrives -> IF/ID frozen and no ImemReq; on release,
//     the buffered word appears in 1 cycle.
//  4. Redirect to 0x40 while a latency-3 fetch of 0x8 is in flight -> the 0x8 data is dropped and
//     never reaches IF/ID; next ImemAddr=0x40; IfIdValid=0 meanwhile.
//  5. Redirect to 0x103 coinciding with ImemValid -> data dropped; ImemAddr=0x100 next cycle.
//  6. Reset asserted during WAIT -> all outputs 0 asynchronously; the late ImemValid is ignored;
//     first request after release is at RESET_PC.

Source files
------------

// File: rtl/instr_fetch_stage.sv
// Fetch stage with IF/ID pipeline register: owns the PC and keeps a single request
// outstanding to instruction memory, honouring decode stalls and branch/jump redirects.
module instr_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Stall,
  input  logic             Redirect,
  input  logic [31:0]      RedirectPC,
  output logic             ImemReq,
  output logic [31:0]      ImemAddr,
  input  logic [31:0]      ImemRData,
  input  logic             ImemValid,
  output logic [31:0]      IfIdInstr,
  output logic [31:0]      IfIdPCPlus4,
  output logic             IfIdValid,
  output logic [CNT_W-1:0] InstrCount
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_HOLD
  } state_t;

  state_t             state_reg, state_next;
  logic [31:0]        pc_reg, pc_next;
  logic               kill_reg, kill_next;
  logic               req_reg, req_next;
  logic [31:0]        addr_reg, addr_next;
  logic [31:0]        instr_reg, instr_next;
  logic [31:0]        pc4_reg, pc4_next;
  logic               valid_reg, valid_next;
  logic [CNT_W-1:0]   count_reg, count_next;
  logic [31:0]        hold_reg, hold_next;

  logic [31:0] pc_plus4;
  logic [31:0] redirect_pc;
  logic        issue;
  logic        deliver;
  logic [31:0] deliver_word;

  assign pc_plus4    = pc_reg + 32'd4;
  assign redirect_pc = RedirectPC & 32'hFFFF_FFFC;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_reg <= S_IDLE;
      pc_reg    <= RESET_PC;
      kill_reg  <= 1'b0;
      req_reg   <= 1'b0;
      addr_reg  <= 32'd0;
      instr_reg <= 32'd0;
      pc4_reg   <= 32'd0;
      valid_reg <= 1'b0;
      count_reg <= '0;
      hold_reg  <= 32'd0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      kill_reg  <= kill_next;
      req_reg   <= req_next;
      addr_reg  <= addr_next;
      instr_reg <= instr_next;
      pc4_reg   <= pc4_next;
      valid_reg <= valid_next;
      count_reg <= count_next;
      hold_reg  <= hold_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    pc_next      = pc_reg;
    kill_next    = kill_reg;
    req_next     = 1'b0;
    addr_next    = addr_reg;
    instr_next   = instr_reg;
    pc4_next     = pc4_reg;
    valid_next   = valid_reg;
    count_next   = count_reg;
    hold_next    = hold_reg;
    issue        = 1'b0;
    deliver      = 1'b0;
    deliver_word = hold_reg;

    case (state_reg)
      S_IDLE: begin
        // IDLE doubles as the "request pending" state while decode is stalled.
        if (Redirect) begin
          pc_next    = redirect_pc;
          instr_next = 32'd0;
          valid_next = 1'b0;
          hold_next  = 32'd0;
          state_next = S_WAIT;
          issue      = 1'b1;
        end else if (!Stall) begin
          state_next = S_WAIT;
          issue      = 1'b1;
        end
      end

      S_WAIT: begin
        if (Redirect) begin
          pc_next    = redirect_pc;
          instr_next = 32'd0;
          valid_next = 1'b0;
          hold_next  = 32'd0;
          if (ImemValid) begin
            kill_next = 1'b0;
            issue     = 1'b1;
          end else begin
            kill_next = 1'b1;
          end
        end else if (ImemValid) begin
          if (kill_reg) begin
            // Squashed response: refetch the redirect target, deferring it under stall.
            kill_next = 1'b0;
            if (Stall) state_next = S_IDLE;
            else       issue      = 1'b1;
          end else if (Stall) begin
            hold_next  = ImemRData;
            state_next = S_HOLD;
          end else begin
            deliver      = 1'b1;
            deliver_word = ImemRData;
          end
        end
      end

      S_HOLD: begin
        if (Redirect) begin
          pc_next    = redirect_pc;
          instr_next = 32'd0;
          valid_next = 1'b0;
          hold_next  = 32'd0;
          state_next = S_WAIT;
          issue      = 1'b1;
        end else if (!Stall) begin
          deliver      = 1'b1;
          deliver_word = hold_reg;
        end
      end

      default: state_next = S_IDLE;
    endcase

    if (deliver) begin
      instr_next = deliver_word;
      pc4_next   = pc_plus4;
      valid_next = 1'b1;
      count_next = count_reg + CNT_W'(1);
      pc_next    = pc_plus4;
      state_next = S_WAIT;
      issue      = 1'b1;
    end

    // The request address is the PC being entered, so a redirect fetches its target at once.
    if (issue) begin
      req_next  = 1'b1;
      addr_next = pc_next;
    end
  end

  assign ImemReq     = req_reg;
  assign ImemAddr    = addr_reg;
  assign IfIdInstr   = instr_reg;
  assign IfIdPCPlus4 = pc4_reg;
  assign IfIdValid   = valid_reg;
  assign InstrCount  = count_reg;

endmodule
